// File: rtl/voice_phase_scheduler_pkg.sv
// Shared types and constants for the voice phase scheduler.
// Fixed phase width, FSM encoding, output beat bundle, clog2 helper.
package voice_phase_scheduler_pkg;

  localparam int PHASE_W = 18;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic               wrap;
  } beat_t;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/voice_phase_scheduler_phase_adder.sv
// Pure combinational PHASE_W-bit adder: sum = a + b + c_in, c_out = carry.
// Ports: a, b, c_in in; sum, c_out out.
module phase_adder
  import voice_phase_scheduler_pkg::*;
(
  input  logic [PHASE_W-1:0] a,
  input  logic [PHASE_W-1:0] b,
  input  logic               c_in,
  output logic [PHASE_W-1:0] sum,
  output logic               c_out
);

  assign {c_out, sum} = {1'b0, a}
                      + {1'b0, b}
                      + {{PHASE_W{1'b0}}, c_in};

endmodule

// File: rtl/voice_phase_scheduler.sv
// Sweeps one shared adder over all voice phase accumulators per sample_tick.
// Ports: clk/reset_n, sample_tick, cfg_* writes; phase/voice/wrap stream, status.
module voice_phase_scheduler
  import voice_phase_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int VIDX_W     = clog2_f(NUM_VOICES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              cfg_we,
  input  logic              cfg_sync,
  input  logic [VIDX_W-1:0] cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  output logic [PHASE_W-1:0] phase_out,
  output logic [VIDX_W-1:0] voice_out,
  output logic              wrap_out,
  output logic              phase_valid,
  output logic              busy,
  output logic              sweep_done,
  output logic              overrun
);

  localparam logic [VIDX_W-1:0] LAST =
    VIDX_W'(NUM_VOICES - 1);
  localparam logic [VIDX_W:0] NV =
    (VIDX_W + 1)'(NUM_VOICES);

  state_e            state_q, state_d;
  logic [VIDX_W-1:0] idx_q, idx_d;

  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];
  logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0] inc_d   [NUM_VOICES];

  beat_t             beat_q, beat_d;
  logic [VIDX_W-1:0] voice_q, voice_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic [PHASE_W-1:0] add_sum;
  logic               add_cout;
  logic               sweeping;
  logic               cfg_ok;

  assign sweeping = (state_q == S_SWEEP);
  assign cfg_ok   = ({1'b0, cfg_voice} < NV);

  phase_adder u_adder (
    .a     (phase_q[idx_q]),
    .b     (inc_q[idx_q]),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + VIDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    phase_d   = phase_q;
    inc_d     = inc_q;
    beat_d    = beat_q;
    voice_d   = voice_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun_q | (sample_tick & sweeping);

    if (sweeping) begin
      phase_d[idx_q] = add_sum;
      beat_d.phase   = add_sum;
      beat_d.wrap    = add_cout;
      voice_d        = idx_q;
      valid_d        = 1'b1;
      done_d         = (idx_q == LAST);
    end

    // The add above reads inc_q, so a same-cycle write only
    // affects the next sweep.
    if (cfg_we && cfg_ok) begin
      inc_d[cfg_voice] = cfg_inc;
    end

    // Hard sync overrides a same-cycle add on that voice and
    // is reported as a wrap so the waveform stage resets too.
    if (cfg_sync && cfg_ok) begin
      phase_d[cfg_voice] = '0;
      if (sweeping && (cfg_voice == idx_q)) begin
        beat_d.phase = '0;
        beat_d.wrap  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
      beat_q    <= '0;
      voice_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      beat_q    <= beat_d;
      voice_q   <= voice_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign phase_out   = beat_q.phase;
  assign wrap_out    = beat_q.wrap;
  assign voice_out   = voice_q;
  assign phase_valid = valid_q;
  assign sweep_done  = done_q;
  assign busy        = sweeping;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_voice_phase_scheduler.sv
// Self-checking bench for voice_phase_scheduler.
// Directed plus randomized sweeps against an arithmetic phase model.
module tb_voice_phase_scheduler;

  localparam int N   = 8;
  localparam int MOD = 1 << 18;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_sync = 1'b0;
  logic [2:0]  cfg_voice = '0;
  logic [17:0] cfg_inc = '0;
  logic [17:0] phase_out;
  logic [2:0]  voice_out;
  logic        wrap_out;
  logic        phase_valid;
  logic        busy;
  logic        sweep_done;
  logic        overrun;

  int          errors = 0;
  int          checks = 0;
  int unsigned phase_m [N];
  int unsigned inc_m   [N];
  logic        ovr_m = 1'b0;

  voice_phase_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_sync    (cfg_sync),
    .cfg_voice   (cfg_voice),
    .cfg_inc     (cfg_inc),
    .phase_out   (phase_out),
    .voice_out   (voice_out),
    .wrap_out    (wrap_out),
    .phase_valid (phase_valid),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_phase"}, 32'(phase_out), 0);
    chk({tag, "_voice"}, 32'(voice_out), 0);
    chk({tag, "_wrap"},  32'(wrap_out), 0);
    chk({tag, "_valid"}, 32'(phase_valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(sweep_done), 0);
    chk({tag, "_ovr"},   32'(overrun), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      phase_m[i] = 0;
      inc_m[i]   = 0;
    end
    ovr_m = 1'b0;
  endtask

  task automatic cfg_write(input int v, input int unsigned val);
    int unsigned m;
    m         = val % MOD;
    cfg_we    = 1'b1;
    cfg_voice = 3'(v);
    cfg_inc   = 18'(m);
    step();
    cfg_we    = 1'b0;
    inc_m[v]  = m;
  endtask

  task automatic cfg_sync_idle(input int v);
    cfg_sync   = 1'b1;
    cfg_voice  = 3'(v);
    step();
    cfg_sync   = 1'b0;
    phase_m[v] = 0;
  endtask

  // Hooks: *_at gives the sweep slot (voice index being added)
  // during which the input is held; -1 disables the hook.
  task automatic sweep(input int we_at, input int sy_at,
                       input int cv, input int unsigned we_val,
                       input int tk_at);
    int unsigned s, ep;
    logic        ew;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_valid", 32'(phase_valid), 0);
    for (int v = 0; v < N; v++) begin
      if (v == we_at) begin
        cfg_we    = 1'b1;
        cfg_inc   = 18'(we_val % MOD);
        cfg_voice = 3'(cv);
      end
      if (v == sy_at) begin
        cfg_sync  = 1'b1;
        cfg_voice = 3'(cv);
      end
      if (v == tk_at) sample_tick = 1'b1;
      s  = phase_m[v] + inc_m[v];
      ep = s % MOD;
      ew = (s >= MOD);
      if (v == sy_at && cv == v) begin
        ep = 0;
        ew = 1'b1;
      end
      phase_m[v] = ep;
      step();
      cfg_we      = 1'b0;
      cfg_sync    = 1'b0;
      sample_tick = 1'b0;
      if (v == we_at) inc_m[cv] = we_val % MOD;
      if (v == sy_at) phase_m[cv] = 0;
      if (v == tk_at) ovr_m = 1'b1;
      chk("valid", 32'(phase_valid), 1);
      chk("voice", 32'(voice_out), 32'(v));
      chk("phase", 32'(phase_out), ep);
      chk("wrap", 32'(wrap_out), 32'(ew));
      chk("done", 32'(sweep_done), 32'(v == N - 1));
      chk("busy", 32'(busy), 32'(v != N - 1));
      chk("overrun", 32'(overrun), 32'(ovr_m));
    end
    step();
    chk("post_valid", 32'(phase_valid), 0);
    chk("post_done", 32'(sweep_done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("hold_phase", 32'(phase_out), ep);
    chk("hold_voice", 32'(voice_out), N - 1);
    chk("hold_wrap", 32'(wrap_out), 32'(ew));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    step();
    chk_zero_outputs("idle");

    // Basic sweep, sweep_done with voice 7.
    cfg_write(0, 1);
    cfg_write(1, 'h100);
    sweep(-1, -1, 0, 0, -1);

    // Exact half-range increment wraps every other sweep.
    cfg_write(2, 'h20000);
    repeat (3) sweep(-1, -1, 0, 0, -1);

    // Max increment from phase 0.
    cfg_sync_idle(3);
    cfg_write(3, 'h3FFFF);
    repeat (2) sweep(-1, -1, 0, 0, -1);

    // Tick mid-sweep, then on the final sweep cycle.
    sweep(-1, -1, 0, 0, 3);
    sweep(-1, -1, 0, 0, -1);
    sweep(-1, -1, 0, 0, N - 1);

    // Same-cycle increment write and hard sync.
    cfg_write(4, 1);
    sweep(4, -1, 4, 'h10, -1);
    sweep(-1, -1, 0, 0, -1);
    cfg_write(5, 'h3F000);
    sweep(-1, -1, 0, 0, -1);
    sweep(-1, 5, 5, 0, -1);
    sweep(2, 2, 6, 'h2345, -1);
    sweep(-1, -1, 0, 0, -1);

    // Reset asserted mid-sweep at idx 3.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (3) step();
    chk("mid_valid", 32'(phase_valid), 1);
    chk("mid_voice", 32'(voice_out), 2);
    reset_n = 1'b0;
    #2;
    model_reset();
    chk_zero_outputs("abort");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_valid", 32'(phase_valid), 0);
      chk("after_rst_busy", 32'(busy), 0);
    end
    cfg_write(0, 'h7);
    sweep(-1, -1, 0, 0, -1);

    // Randomized increments, hooks and overlapping ticks.
    for (int r = 0; r < 12; r++) begin
      for (int v = 0; v < N; v++) begin
        if ($urandom_range(0, 1) == 1)
          cfg_write(v, $urandom_range(0, MOD - 1));
      end
      if ($urandom_range(0, 3) == 0)
        cfg_sync_idle(int'($urandom_range(0, N - 1)));
      sweep(int'($urandom_range(0, N)) - 1,
            int'($urandom_range(0, N)) - 1,
            int'($urandom_range(0, N - 1)),
            $urandom_range(0, MOD - 1),
            int'($urandom_range(0, 2 * N)) - N);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
